// File: rtl/bolme_seq.sv
// bolme_seq: sequential restoring divider, one quotient bit per clock.
// It uses the same start/done handshake as the shift-add multiplier, so
// one control FSM can drive either block.
//
// Optional feature macro: BOLME_SEQ_SIGNED_EN
//   undefined : unsigned operands and results
//   defined   : two's complement operands, truncating division
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   start        request; accepted only while idle
//   dividend     numerator, sampled at acceptance
//   divisor      denominator, sampled at acceptance
//   quotient     registered result
//   remainder    registered result
//   done         one-cycle pulse, results valid
//   busy         division in progress
//   div_by_zero  last completed division had divisor == 0
//
// state  | meaning
// S_IDLE | waiting for start
// S_CALC | one restoring step per edge, counter runs down to 1
// S_DONE | entered with done=1 after CALC; entered with done=0 on
//        | divide-by-zero, where the next edge raises done
module bolme_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         done,
    output logic         busy,
    output logic         div_by_zero
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N:0]    r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          dbz_q, dbz_d;
`ifdef BOLME_SEQ_SIGNED_EN
    logic          neg_quo_q, neg_quo_d;
    logic          neg_rem_q, neg_rem_d;
`endif

    logic [N-1:0]  dvd_mag, dvs_mag;
    logic [N:0]    r_sh, trial, r_step;
    logic [N-1:0]  a_step;
    logic [N-1:0]  q_res, r_res;
    logic          last_step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            dbz_q       <= 1'b0;
`ifdef BOLME_SEQ_SIGNED_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            dbz_q       <= dbz_d;
`ifdef BOLME_SEQ_SIGNED_EN
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

    assign last_step = (cnt_q == CW'(1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (divisor == '0) ? S_DONE : S_CALC;
            S_CALC: if (last_step) state_d = S_DONE;
            S_DONE: if (done_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One restoring step: shift {R,A} left, trial-subtract B, and keep the
    // difference only when it did not go negative.
    always_comb begin
        r_sh   = {r_q[N-1:0], a_q[N-1]};
        trial  = r_sh - {1'b0, b_q};
        r_step = trial[N] ? r_sh : trial;
        a_step = {a_q[N-2:0], ~trial[N]};
`ifdef BOLME_SEQ_SIGNED_EN
        dvd_mag = dividend[N-1] ? -dividend : dividend;
        dvs_mag = divisor[N-1]  ? -divisor  : divisor;
        q_res   = neg_quo_q ? -a_step : a_step;
        r_res   = neg_rem_q ? -r_step[N-1:0] : r_step[N-1:0];
`else
        dvd_mag = dividend;
        dvs_mag = divisor;
        q_res   = a_step;
        r_res   = r_step[N-1:0];
`endif
    end

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        dbz_d       = dbz_q;
`ifdef BOLME_SEQ_SIGNED_EN
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // On divide-by-zero A keeps the raw dividend, which
                    // becomes the remainder one edge later.
                    a_d    = (divisor == '0) ? dividend : dvd_mag;
                    b_d    = dvs_mag;
                    r_d    = '0;
                    cnt_d  = CW'(N);
                    busy_d = 1'b1;
`ifdef BOLME_SEQ_SIGNED_EN
                    neg_quo_d = dividend[N-1] ^ divisor[N-1];
                    neg_rem_d = dividend[N-1];
`endif
                end
            end
            S_CALC: begin
                a_d   = a_step;
                r_d   = r_step;
                cnt_d = cnt_q - CW'(1);
                if (last_step) begin
                    quotient_d  = q_res;
                    remainder_d = r_res;
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            S_DONE: begin
                if (!done_q) begin
                    quotient_d  = '1;
                    remainder_d = a_q;
                    dbz_d       = 1'b1;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        quotient    = quotient_q;
        remainder   = remainder_q;
        done        = done_q;
        busy        = busy_q;
        div_by_zero = dbz_q;
    end
endmodule

// File: tb/tb_bolme_seq.sv
module tb_bolme_seq;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         done;
    logic         busy;
    logic         div_by_zero;

    always #5 clk = ~clk;

    bolme_seq #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    int vectors    = 0;
    int miscompares = 0;
    bit armed      = 1'b0;

    // Reference model: cycles left until done, plus a one-cycle cooldown
    // after done during which start is ignored.
    int           m_wait = 0;
    bit           m_cool = 1'b0;
    logic [N-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic         m_done = 1'b0, m_busy = 1'b0, m_z = 1'b0, p_z = 1'b0;

    function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                    output logic [N-1:0] q, output logic [N-1:0] r,
                                    output logic z);
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
`ifdef BOLME_SEQ_SIGNED_EN
            int sa, sb;
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = N'(sa / sb);
            r  = N'(sa % sb);
`else
            q  = a / b;
            r  = a % b;
`endif
            z  = 1'b0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_wait = 0;
            m_cool = 1'b0;
            m_q    = '0;
            m_r    = '0;
            m_z    = 1'b0;
            m_done = 1'b0;
            m_busy = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_cool) begin
                m_cool = 1'b0;
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                    m_q    = p_q;
                    m_r    = p_r;
                    m_z    = p_z;
                    m_cool = 1'b1;
                end
            end else if (start) begin
                ref_div(dividend, divisor, p_q, p_r, p_z);
                m_wait = (divisor == '0) ? 1 : N;
                m_busy = 1'b1;
            end
        end
        armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            check("done", 32'(done), 32'(m_done));
            check("busy", 32'(busy), 32'(m_busy));
            check("quotient", 32'(quotient), 32'(m_q));
            check("remainder", 32'(remainder), 32'(m_r));
            check("div_by_zero", 32'(div_by_zero), 32'(m_z));
        end
    end

    // Issue one op and wait (bounded) for done; optionally pulse a second,
    // ignored request pulse_at negedges after acceptance.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] eq, input logic [N-1:0] er,
                         input logic ez, input int lat, input int pulse_at);
        int k;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
        k = 0;
        while (done !== 1'b1 && k < 4 * N) begin
            @(negedge clk);
            k++;
            start = (k == pulse_at);
            if (start) begin
                dividend = 8'd50;
                divisor  = 8'd5;
            end
        end
        start = 1'b0;
        check("op_latency", 32'(k), 32'(lat));
        check("op_quotient", 32'(quotient), 32'(eq));
        check("op_remainder", 32'(remainder), 32'(er));
        check("op_dbz", 32'(div_by_zero), 32'(ez));
        check("model_quotient", 32'(m_q), 32'(eq));
        check("model_remainder", 32'(m_r), 32'(er));
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        do_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, N, -1);
        do_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, N, -1);
        do_op(8'd5, 8'd10, 8'd0, 8'd5, 1'b0, N, -1);
        do_op(8'd42, 8'd0, 8'd255, 8'd42, 1'b1, 1, -1);
        do_op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, N, -1);
`ifdef BOLME_SEQ_SIGNED_EN
        do_op(8'd200, 8'd9, 8'hFA, 8'hFE, 1'b0, N, 2);
`else
        do_op(8'd200, 8'd9, 8'd22, 8'd2, 1'b0, N, 2);
`endif

        // Reset in the middle of a division.
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (N + 2) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        do_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, N, -1);

`ifdef BOLME_SEQ_SIGNED_EN
        do_op(8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, N, -1);
        do_op(8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, N, -1);
        do_op(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, N, -1);
`endif

        // Random traffic: held and pulsed starts, zero divisors, rare resets.
        repeat (4000) begin
            @(negedge clk);
            rst_n    = ($urandom_range(0, 299) != 0);
            start    = ($urandom_range(0, 2) == 0);
            dividend = N'($urandom);
            case ($urandom_range(0, 7))
                0:       divisor = '0;
                1, 2:    divisor = N'($urandom_range(1, 15));
                default: divisor = N'($urandom);
            endcase
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
